// File: rtl/apb_slot_guard_if.sv
// Purpose: APB3 link between the MSS fabric master port and the slot guard.
// Latency: wires only.
// Backpressure: MSSPREADY stretches the access phase; MSSPSLVERR flags a failed transfer.
// Ports: MSSPSEL/MSSPENABLE/MSSPWRITE/MSSPADDR/MSSPWDATA come from the master;
//        MSSPRDATA/MSSPREADY/MSSPSLVERR return to it.
interface apb_slot_guard_if;
    logic        MSSPSEL;
    logic        MSSPENABLE;
    logic        MSSPWRITE;
    logic [31:0] MSSPADDR;
    logic [31:0] MSSPWDATA;
    logic [31:0] MSSPRDATA;
    logic        MSSPREADY;
    logic        MSSPSLVERR;

    modport master (
        output MSSPSEL, MSSPENABLE, MSSPWRITE, MSSPADDR, MSSPWDATA,
        input  MSSPRDATA, MSSPREADY, MSSPSLVERR
    );

    modport slave (
        input  MSSPSEL, MSSPENABLE, MSSPWRITE, MSSPADDR, MSSPWDATA,
        output MSSPRDATA, MSSPREADY, MSSPSLVERR
    );
endinterface

// File: rtl/apb_slot_guard.sv
// Purpose: APB3 slot decoder with a hung-slave timeout, decode-error response and fault STATUS/IRQ.
// Latency: zero added cycles on the normal path; a timeout ends the access phase after TIMEOUT+2 cycles.
// Backpressure: slot PREADY passes straight to the master; STATUS and unmapped slots answer with zero waits.
// Ports: FAB_CLK/M2F_RESET_N clock and async active-low reset; mss is the master-facing APB3 link;
//        S_* fan out to NUM_SLOTS peripherals (shared enable/write/addr/wdata, per-slot sel/ready/err/rdata);
//        BUS_ERR_IRQ is high while either fault sticky bit is set.
module apb_slot_guard #(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_LSB  = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic                      FAB_CLK,
    input  logic                      M2F_RESET_N,
    apb_slot_guard_if.slave           mss,
    output logic [NUM_SLOTS-1:0]      S_PSEL,
    output logic                      S_PENABLE,
    output logic                      S_PWRITE,
    output logic [SLOT_LSB-1:0]       S_PADDR,
    output logic [31:0]               S_PWDATA,
    input  logic [NUM_SLOTS-1:0]      S_PREADY,
    input  logic [NUM_SLOTS-1:0]      S_PSLVERR,
    input  logic [32*NUM_SLOTS-1:0]   S_PRDATA,
    output logic                      BUS_ERR_IRQ
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ABORT} state_t;

    localparam logic [3:0] STATUS_IDX  = 4'(NUM_SLOTS);
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state, state_nxt;
    logic [7:0]  wait_cnt, wait_cnt_nxt;

    // STATUS fields, kept as separate registers
    logic        to_sticky, to_sticky_nxt;
    logic        de_sticky, de_sticky_nxt;
    logic [3:0]  fault_slot, fault_slot_nxt;
    logic [7:0]  to_count, to_count_nxt;
    logic [31:0] status_word;

    logic [3:0]  idx;
    logic        is_periph, is_status, is_unmapped;
    logic        live, access, in_xfer, timed_out;
    logic        slot_rdy, slot_err;
    logic [31:0] slot_rdata;
    logic        mss_rdy, mss_err;
    logic [31:0] mss_rdata;
    logic        unused_addr_bits;

    assign idx         = mss.MSSPADDR[SLOT_LSB+3:SLOT_LSB];
    assign is_periph   = idx <  STATUS_IDX;
    assign is_status   = idx == STATUS_IDX;
    assign is_unmapped = idx >  STATUS_IDX;

    // Reset gates every master/slave-facing response immediately, not at the next edge.
    assign live    = M2F_RESET_N & mss.MSSPSEL;
    assign access  = mss.MSSPSEL & mss.MSSPENABLE;
    // From IDLE the first access cycle is spent in SETUP, so both states run the access logic.
    assign in_xfer = (state == SETUP) || (state == ACCESS);

    assign unused_addr_bits = ^{mss.MSSPADDR[31:SLOT_LSB+4]};

    assign status_word = {14'b0, to_sticky, de_sticky, 4'b0, fault_slot, to_count};
    assign BUS_ERR_IRQ = to_sticky | de_sticky;

    // Shared slave-side signals are pure pass-through.
    assign S_PENABLE = mss.MSSPENABLE;
    assign S_PWRITE  = mss.MSSPWRITE;
    assign S_PADDR   = mss.MSSPADDR[SLOT_LSB-1:0];
    assign S_PWDATA  = mss.MSSPWDATA;

    // Response mux from the addressed slot (loop avoids indexing past NUM_SLOTS).
    always_comb begin
        slot_rdy   = 1'b0;
        slot_err   = 1'b0;
        slot_rdata = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (idx == 4'(i)) begin
                slot_rdy   = S_PREADY[i];
                slot_err   = S_PSLVERR[i];
                slot_rdata = S_PRDATA[32*i +: 32];
            end
        end
    end

    // Select is one-hot by construction and withdrawn while the abort response is given.
    always_comb begin
        S_PSEL = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            S_PSEL[i] = live && is_periph && (idx == 4'(i)) && (state != ABORT);
        end
    end

    always_comb begin
        mss_rdy   = 1'b0;
        mss_err   = 1'b0;
        mss_rdata = '0;
        if (live) begin
            if (state == ABORT) begin
                mss_rdy = 1'b1;
                mss_err = 1'b1;
            end else if (is_periph) begin
                mss_rdy   = slot_rdy;
                mss_err   = slot_err;
                mss_rdata = slot_rdata;
            end else if (is_status) begin
                mss_rdy   = 1'b1;
                mss_rdata = status_word;
            end else begin
                mss_rdy = 1'b1;
                mss_err = 1'b1;
            end
        end
    end

    assign mss.MSSPREADY  = mss_rdy;
    assign mss.MSSPSLVERR = mss_err;
    assign mss.MSSPRDATA  = mss_rdata;

    // A slave answering in the very cycle the budget runs out still wins.
    assign timed_out = in_xfer && access && is_periph && !slot_rdy && (wait_cnt == TIMEOUT_CNT);

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        unique case (state)
            IDLE: begin
                if (mss.MSSPSEL && !mss.MSSPENABLE) begin
                    state_nxt = SETUP;
                end
            end
            SETUP, ACCESS: begin
                if (!mss.MSSPSEL) begin
                    // master gave up mid-transfer: drop back without recording a fault
                    state_nxt    = IDLE;
                    wait_cnt_nxt = '0;
                end else if (!access) begin
                    // setup cycle of a back-to-back transfer
                    state_nxt    = ACCESS;
                    wait_cnt_nxt = '0;
                end else if (mss_rdy) begin
                    // PSEL is still high here; a released bus is caught from SETUP next cycle
                    state_nxt    = SETUP;
                    wait_cnt_nxt = '0;
                end else if (timed_out) begin
                    state_nxt    = ABORT;
                    wait_cnt_nxt = '0;
                end else begin
                    state_nxt    = ACCESS;
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            ABORT: begin
                state_nxt = mss.MSSPSEL ? SETUP : IDLE;
            end
            default: begin
                state_nxt    = IDLE;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // Clearing write is applied first so a fault landing in the same cycle survives it.
    always_comb begin
        to_sticky_nxt  = to_sticky;
        de_sticky_nxt  = de_sticky;
        fault_slot_nxt = fault_slot;
        to_count_nxt   = to_count;
        if (in_xfer && access && is_status && mss.MSSPWRITE) begin
            to_sticky_nxt  = 1'b0;
            de_sticky_nxt  = 1'b0;
            fault_slot_nxt = '0;
            to_count_nxt   = '0;
        end
        if (timed_out) begin
            to_sticky_nxt  = 1'b1;
            fault_slot_nxt = idx;
            if (to_count != 8'hFF) begin
                to_count_nxt = to_count + 8'd1;
            end
        end
        if (in_xfer && access && is_unmapped) begin
            de_sticky_nxt  = 1'b1;
            fault_slot_nxt = idx;
        end
    end

    always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
        if (!M2F_RESET_N) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            to_sticky  <= 1'b0;
            de_sticky  <= 1'b0;
            fault_slot <= '0;
            to_count   <= '0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            to_sticky  <= to_sticky_nxt;
            de_sticky  <= de_sticky_nxt;
            fault_slot <= fault_slot_nxt;
            to_count   <= to_count_nxt;
        end
    end

endmodule

// File: tb/tb_apb_slot_guard.sv
// Purpose: directed self-checking bench for apb_slot_guard with a queued expected-response scoreboard.
// Latency: each transfer is one setup cycle plus the observed access cycles.
// Backpressure: the bench plays the slot slaves, holding PREADY low for a chosen number of cycles.
module tb_apb_slot_guard;
    localparam int NUM_SLOTS = 4;
    localparam int SLOT_LSB  = 8;
    localparam int TIMEOUT   = 64;
    localparam logic [31:0] STATUS_ADDR = 32'h0000_0400;
    localparam int MAX_ACCESS = 300;

    typedef struct {
        logic [31:0]          rdata;
        logic                 err;
        int                   cycles;
        logic [NUM_SLOTS-1:0] psel_done;
    } exp_t;

    typedef struct {
        logic [31:0]          rdata;
        logic                 err;
        int                   cycles;
        logic [NUM_SLOTS-1:0] psel_done;
        logic                 hold_ok;
        logic                 pass_ok;
    } obs_t;

    logic                    FAB_CLK = 1'b0;
    logic                    M2F_RESET_N;
    logic [NUM_SLOTS-1:0]    S_PSEL;
    logic                    S_PENABLE;
    logic                    S_PWRITE;
    logic [SLOT_LSB-1:0]     S_PADDR;
    logic [31:0]             S_PWDATA;
    logic [NUM_SLOTS-1:0]    S_PREADY;
    logic [NUM_SLOTS-1:0]    S_PSLVERR;
    logic [32*NUM_SLOTS-1:0] S_PRDATA;
    logic                    BUS_ERR_IRQ;

    int checks = 0;
    int passed = 0;
    exp_t sb[$];

    apb_slot_guard_if mss ();

    always #5 FAB_CLK = ~FAB_CLK;

    apb_slot_guard #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_LSB  (SLOT_LSB),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .FAB_CLK     (FAB_CLK),
        .M2F_RESET_N (M2F_RESET_N),
        .mss         (mss),
        .S_PSEL      (S_PSEL),
        .S_PENABLE   (S_PENABLE),
        .S_PWRITE    (S_PWRITE),
        .S_PADDR     (S_PADDR),
        .S_PWDATA    (S_PWDATA),
        .S_PREADY    (S_PREADY),
        .S_PSLVERR   (S_PSLVERR),
        .S_PRDATA    (S_PRDATA),
        .BUS_ERR_IRQ (BUS_ERR_IRQ)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic exp_t mk(input logic [31:0] rdata, input logic err, input int cycles,
                                input logic [NUM_SLOTS-1:0] psel_done);
        exp_t e;
        e.rdata     = rdata;
        e.err       = err;
        e.cycles    = cycles;
        e.psel_done = psel_done;
        return e;
    endfunction

    // One APB transfer; slot slave raises PREADY once rdy_after access cycles have passed (-1 = never).
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input int rdy_after, output obs_t o);
        logic [3:0]           idx;
        logic [NUM_SLOTS-1:0] psel_exp;
        logic                 done;
        idx      = addr[SLOT_LSB+3:SLOT_LSB];
        psel_exp = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (int'(idx) == i) psel_exp[i] = 1'b1;
        end
        o.rdata     = 'x;
        o.err       = 1'bx;
        o.psel_done = 'x;
        o.pass_ok   = 1'b0;
        o.cycles    = 0;
        done        = 1'b0;

        @(posedge FAB_CLK); #1;
        mss.MSSPSEL    = 1'b1;
        mss.MSSPENABLE = 1'b0;
        mss.MSSPWRITE  = wr;
        mss.MSSPADDR   = addr;
        mss.MSSPWDATA  = wdata;
        @(negedge FAB_CLK);
        o.hold_ok = (S_PSEL === psel_exp);

        while (!done && o.cycles < MAX_ACCESS) begin
            @(posedge FAB_CLK); #1;
            mss.MSSPENABLE = 1'b1;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (int'(idx) == i && rdy_after >= 0 && o.cycles >= rdy_after) S_PREADY[i] = 1'b1;
            end
            @(negedge FAB_CLK);
            o.cycles++;
            if (o.cycles == 1) begin
                o.pass_ok = (S_PADDR === addr[SLOT_LSB-1:0]) && (S_PWDATA === wdata) &&
                            (S_PWRITE === wr) && (S_PENABLE === 1'b1);
            end
            if (mss.MSSPREADY === 1'b1) begin
                done        = 1'b1;
                o.rdata     = mss.MSSPRDATA;
                o.err       = mss.MSSPSLVERR;
                o.psel_done = S_PSEL;
            end else if (S_PSEL !== psel_exp) begin
                o.hold_ok = 1'b0;
            end
        end

        @(posedge FAB_CLK); #1;
        mss.MSSPSEL    = 1'b0;
        mss.MSSPENABLE = 1'b0;
        S_PREADY       = '0;
    endtask

    task automatic step(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int rdy_after, input exp_t e);
        obs_t o;
        exp_t x;
        sb.push_back(e);
        apb_xfer(wr, addr, wdata, rdy_after, o);
        x = sb.pop_front();
        check({tag, ".cycles"},    32'(o.cycles),    32'(x.cycles));
        check({tag, ".rdata"},     o.rdata,          x.rdata);
        check({tag, ".slverr"},    32'(o.err),       32'(x.err));
        check({tag, ".psel_done"}, 32'(o.psel_done), 32'(x.psel_done));
        check({tag, ".psel_hold"}, 32'(o.hold_ok),   32'd1);
        check({tag, ".passthru"},  32'(o.pass_ok),   32'd1);
    endtask

    initial begin
        mss.MSSPSEL    = 1'b0;
        mss.MSSPENABLE = 1'b0;
        mss.MSSPWRITE  = 1'b0;
        mss.MSSPADDR   = '0;
        mss.MSSPWDATA  = '0;
        S_PREADY       = '0;
        S_PSLVERR      = '0;
        S_PRDATA       = {32'hD3D3_3333, 32'hC2C2_2222, 32'h1234_5678, 32'hA0A0_0000};
        M2F_RESET_N    = 1'b0;

        // reset state
        repeat (3) @(negedge FAB_CLK);
        check("rst.ready",  32'(mss.MSSPREADY),  32'd0);
        check("rst.slverr", 32'(mss.MSSPSLVERR), 32'd0);
        check("rst.rdata",  mss.MSSPRDATA,       32'd0);
        check("rst.psel",   32'(S_PSEL),         32'd0);
        check("rst.irq",    32'(BUS_ERR_IRQ),    32'd0);
        @(posedge FAB_CLK); #1;
        M2F_RESET_N = 1'b1;

        // normal zero-wait read, then STATUS untouched
        step("rd_slot1", 1'b0, 32'h0000_0100, 32'h0, 0, mk(32'h1234_5678, 1'b0, 1, 4'b0010));
        step("rd_status_a", 1'b0, STATUS_ADDR, 32'h0, 0, mk(32'h0, 1'b0, 1, 4'b0000));

        // write with five wait states
        step("wr_slot2", 1'b1, 32'h0000_0204, 32'hCAFE_F00D, 5, mk(32'hC2C2_2222, 1'b0, 6, 4'b0100));

        // stuck slave -> abort after TIMEOUT+2 access cycles
        step("to_slot0", 1'b0, 32'h0000_0010, 32'h0, -1, mk(32'h0, 1'b1, TIMEOUT + 2, 4'b0000));
        step("rd_status_to", 1'b0, STATUS_ADDR, 32'h0, 0, mk(32'h0002_0001, 1'b0, 1, 4'b0000));
        @(negedge FAB_CLK);
        check("irq_after_to", 32'(BUS_ERR_IRQ), 32'd1);

        // unmapped slot, then clearing write
        step("rd_unmapped", 1'b0, 32'h0000_0700, 32'h0, 0, mk(32'h0, 1'b1, 1, 4'b0000));
        step("rd_status_de", 1'b0, STATUS_ADDR, 32'h0, 0, mk(32'h0003_0701, 1'b0, 1, 4'b0000));
        step("wr_status_clr", 1'b1, STATUS_ADDR, 32'hFFFF_FFFF, 0, mk(32'h0003_0701, 1'b0, 1, 4'b0000));
        step("rd_status_clr", 1'b0, STATUS_ADDR, 32'h0, 0, mk(32'h0, 1'b0, 1, 4'b0000));
        @(negedge FAB_CLK);
        check("irq_after_clr", 32'(BUS_ERR_IRQ), 32'd0);

        // ready arrives in the cycle the counter reaches TIMEOUT: slave wins
        step("race_slot1", 1'b0, 32'h0000_0100, 32'h0, TIMEOUT, mk(32'h1234_5678, 1'b0, TIMEOUT + 1, 4'b0010));
        step("rd_status_race", 1'b0, STATUS_ADDR, 32'h0, 0, mk(32'h0, 1'b0, 1, 4'b0000));

        // 256 timeouts on slot 3: count saturates at 0xFF
        for (int n = 0; n < 256; n++) begin
            step("to_sat", 1'b0, 32'h0000_0300, 32'h0, -1, mk(32'h0, 1'b1, TIMEOUT + 2, 4'b0000));
        end
        step("rd_status_sat", 1'b0, STATUS_ADDR, 32'h0, 0, mk(32'h0002_03FF, 1'b0, 1, 4'b0000));

        // reset in the middle of a waited access to slot 3
        @(posedge FAB_CLK); #1;
        mss.MSSPSEL    = 1'b1;
        mss.MSSPENABLE = 1'b0;
        mss.MSSPWRITE  = 1'b0;
        mss.MSSPADDR   = 32'h0000_0300;
        repeat (10) begin
            @(posedge FAB_CLK); #1;
            mss.MSSPENABLE = 1'b1;
        end
        @(negedge FAB_CLK);
        check("midrst.psel_before", 32'(S_PSEL), 32'h8);
        M2F_RESET_N = 1'b0;
        #1;
        check("midrst.psel",   32'(S_PSEL),         32'd0);
        check("midrst.ready",  32'(mss.MSSPREADY),  32'd0);
        check("midrst.slverr", 32'(mss.MSSPSLVERR), 32'd0);
        check("midrst.rdata",  mss.MSSPRDATA,       32'd0);
        check("midrst.irq",    32'(BUS_ERR_IRQ),    32'd0);
        @(posedge FAB_CLK); #1;
        mss.MSSPSEL    = 1'b0;
        mss.MSSPENABLE = 1'b0;
        @(posedge FAB_CLK); #1;
        M2F_RESET_N = 1'b1;

        step("post_rst_slot3", 1'b0, 32'h0000_0300, 32'h0, 2, mk(32'hD3D3_3333, 1'b0, 3, 4'b1000));
        step("rd_status_post", 1'b0, STATUS_ADDR, 32'h0, 0, mk(32'h0, 1'b0, 1, 4'b0000));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/apb_slot_guard.md
Name: apb_slot_guard

Overview:
- Sits between the MSS fabric APB3 master port (MSSP*) and up to 15 fabric APB3 peripherals, for example servo PWM, laser/trigger, and sensor blocks.
- Decodes the address into slots and forwards transfers to the selected slot.
- Protects the MSS from hung or unmapped slaves with a wait-state timeout and a decode-error response.
- Holds a local fault-status register and raises an interrupt line toward the MSS.

Parameters:
- NUM_SLOTS, 4, number of peripheral slots; legal range 1..15.
- SLOT_LSB, 8, LSB of the 4-bit slot index field in MSSPADDR; each slot spans 2^SLOT_LSB bytes.
- TIMEOUT, 64, access-phase wait cycles tolerated before the transfer is aborted; legal range 1..255.

Ports:
- FAB_CLK  in  1  fabric clock, rising-edge.
- M2F_RESET_N  in  1  asynchronous active-low reset.
- MSSPSEL  in  1  master select.
- MSSPENABLE  in  1  master enable.
- MSSPWRITE  in  1  master write.
- MSSPADDR  in  32  master address.
- MSSPWDATA  in  32  master write data.
- MSSPRDATA  out  32  read data to master.
- MSSPREADY  out  1  ready to master.
- MSSPSLVERR  out  1  error to master.
- S_PSEL  out  NUM_SLOTS  per-slot select.
- S_PENABLE  out  1  shared enable.
- S_PWRITE  out  1  shared write.
- S_PADDR  out  SLOT_LSB  slot-local address, equal to MSSPADDR[SLOT_LSB-1:0].
- S_PWDATA  out  32  shared write data.
- S_PREADY  in  NUM_SLOTS  per-slot ready.
- S_PSLVERR  in  NUM_SLOTS  per-slot error.
- S_PRDATA  in  32*NUM_SLOTS  per-slot read data; slot i occupies [32i+31:32i].
- BUS_ERR_IRQ  out  1  level interrupt; high while STATUS[17:16] != 0.

Behaviour:
- Reset (async, M2F_RESET_N=0) forces:
  - state IDLE, wait counter 0, STATUS 0;
  - S_PSEL=0, MSSPREADY=0, MSSPSLVERR=0, MSSPRDATA=0, BUS_ERR_IRQ=0.
- Slot index: idx = MSSPADDR[SLOT_LSB+3:SLOT_LSB].
  - idx < NUM_SLOTS: peripheral slot.
  - idx == NUM_SLOTS: local STATUS register.
  - idx > NUM_SLOTS: unmapped.
- S_PENABLE, S_PWRITE, S_PADDR and S_PWDATA are combinational pass-through. Zero added latency on the normal path.
- State machine (registered):
  - IDLE: when MSSPSEL=1 and MSSPENABLE=0, go to SETUP.
  - SETUP: go to ACCESS on the next cycle.
  - ACCESS:
    - If the response completes (MSSPREADY=1), go to SETUP when MSSPSEL remains 1, otherwise to IDLE.
    - If MSSPSEL falls mid-access (protocol violation), go to IDLE and clear the counter. No STATUS update.
  - ABORT: entered from ACCESS on timeout; returns to IDLE or SETUP like a normal completion.
- Peripheral slot:
  - S_PSEL[idx] = MSSPSEL while state != ABORT.
  - MSSPREADY, MSSPSLVERR and MSSPRDATA mux from slot idx.
- Wait counter (8-bit):
  - Increments each ACCESS cycle with S_PREADY[idx]=0; clears on completion.
  - When counter == TIMEOUT and S_PREADY[idx] is still 0: state goes to ABORT and S_PSEL drops to 0. In ABORT the master sees MSSPREADY=1, MSSPSLVERR=1, MSSPRDATA=0 for exactly one cycle.
  - Total access phase on timeout = TIMEOUT+2 cycles.
  - On abort, STATUS is updated:
    - [17] set;
    - [11:8] = idx;
    - [7:0] incremented, saturating at 255.
- Simultaneous event: if S_PREADY[idx]=1 in the cycle the counter reaches TIMEOUT, the slave response wins and no abort occurs.
- Local STATUS access:
  - Zero wait states, MSSPSLVERR=0.
  - Read returns {14'b0, [17] timeout sticky, [16] decode-error sticky, 4'b0, [11:8] last fault slot, [7:0] timeout count}.
  - Any write clears all STATUS fields at access completion.
  - If a fault is set in the same cycle as a clearing write, the set wins.
- Unmapped slot:
  - Zero wait states, MSSPREADY=1, MSSPSLVERR=1, MSSPRDATA=0, no S_PSEL asserted.
  - STATUS[16] is set and [11:8] = idx.
- MSSPREADY=0 whenever MSSPSEL=0.
- Only one bit of S_PSEL is ever high.
- Reset asserted mid-transfer aborts immediately; the slave sees S_PSEL fall with no completion.

Test Plan:
- Read slot 1 with S_PREADY[1]=1 at the first access cycle and S_PRDATA[63:32]=0x12345678 -> two-cycle transfer, MSSPRDATA=0x12345678, MSSPSLVERR=0, STATUS remains 0.
- Write slot 2 with S_PREADY[2] delayed 5 cycles -> S_PSEL=4'b0100 throughout, MSSPREADY high on access cycle 6, no error.
- Access slot 0 with S_PREADY[0] stuck low and TIMEOUT=64 -> abort after 66 access cycles with PSLVERR=1, PRDATA=0; STATUS=0x0002_0001; BUS_ERR_IRQ=1.
- Read address idx=7 with NUM_SLOTS=4 -> zero-wait PSLVERR=1; STATUS[16]=1 and [11:8]=7. Then write STATUS -> STATUS=0 and BUS_ERR_IRQ=0.
- Slave asserts S_PREADY in the exact cycle the counter hits TIMEOUT -> normal completion, STATUS unchanged. Then force 256 timeouts -> count saturates at 0xFF.
- Assert M2F_RESET_N=0 during a waited access to slot 3 -> S_PSEL=0 and all outputs 0 immediately; after release, a new transfer completes normally.
